// File: rtl/lut_layer_pkg.sv
// Shared types and helpers for the LUT layer pipeline.
package lut_layer_pkg;

  typedef enum logic [1:0] {
    StUncfg,
    StRun,
    StDrain,
    StCfg
  } state_e;

  // Width of the neuron-select field; never narrower than one bit.
  function automatic int unsigned cfg_neuron_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lut_neuron_ram.sv
// Single neuron truth table: one write port, one registered read port.
module lut_neuron_ram #(
  parameter int unsigned FanIn   = 6,
  parameter int unsigned OutBits = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic [FanIn-1:0]   waddr_i,
  input  logic [OutBits-1:0] wdata_i,
  input  logic               re_i,
  input  logic [FanIn-1:0]   raddr_i,
  output logic [OutBits-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** FanIn;

  logic [OutBits-1:0] mem_q [Depth];
  logic [OutBits-1:0] rdata_q;

  // Table storage is deliberately not reset; contents are defined only once loaded.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register doubles as the output stage; it only advances when the stage does.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lut_layer_pipe.sv
// Two-stage LUT neuron layer with a config handshake that drains the pipe first.
module lut_layer_pipe
  import lut_layer_pkg::*;
#(
  parameter int unsigned N_NEURONS = 4,
  parameter int unsigned FAN_IN    = 6,
  parameter int unsigned OUT_BITS  = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_NEURONS*FAN_IN-1:0]          in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [N_NEURONS*OUT_BITS-1:0]        out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  input  logic                                 cfg_req,
  output logic                                 cfg_ack,
  input  logic                                 cfg_we,
  input  logic [cfg_neuron_w(N_NEURONS)-1:0]   cfg_neuron,
  input  logic [FAN_IN-1:0]                    cfg_addr,
  input  logic [OUT_BITS-1:0]                  cfg_data,
  output logic [31:0]                          sample_count
);

  localparam int unsigned NeuronW = cfg_neuron_w(N_NEURONS);

  state_e state_q, state_d;

  logic                          s1_valid_q;
  logic                          s2_valid_q;
  logic [N_NEURONS*FAN_IN-1:0]   s1_addr_q;
  logic [31:0]                   count_q;
  logic                          en1, en2, accept, rd_en, cfg_wr;

  assign en2      = !s2_valid_q || out_ready;
  assign en1      = !s1_valid_q || en2;
  assign in_ready = (state_q == StRun) && en1;
  assign accept   = in_valid && in_ready;
  assign rd_en    = en2 && s1_valid_q;
  assign cfg_ack  = (state_q == StCfg);
  assign cfg_wr   = cfg_ack && cfg_we;

  // Mode sequencing: config is only entered once the datapath is empty.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StUncfg: if (cfg_req) state_d = StCfg;
      StRun:   if (cfg_req) state_d = StDrain;
      StDrain: if (!s1_valid_q && !s2_valid_q) state_d = StCfg;
      StCfg:   if (!cfg_req) state_d = StRun;
      default: state_d = StUncfg;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StUncfg;
    end else begin
      state_q <= state_d;
    end
  end

  // Stage valid flags; a stage loads whenever its enable is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      if (en1) s1_valid_q <= accept;
      if (en2) s2_valid_q <= s1_valid_q;
    end
  end

  // Stage 1 address capture; payload needs no reset since it is qualified by s1_valid_q.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_addr_q <= in_data;
    end
  end

  // Delivered-result counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (out_valid && out_ready) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign out_valid    = s2_valid_q;
  assign sample_count = count_q;

  // Out-of-range neuron indices never match a select, so such writes are dropped.
  for (genvar i = 0; i < N_NEURONS; i++) begin : g_neuron
    logic we;
    assign we = cfg_wr && (cfg_neuron == NeuronW'(i));

    lut_neuron_ram #(
      .FanIn  (FAN_IN),
      .OutBits(OUT_BITS)
    ) u_ram (
      .clk_i  (clk),
      .rst_i  (rst),
      .we_i   (we),
      .waddr_i(cfg_addr),
      .wdata_i(cfg_data),
      .re_i   (rd_en),
      .raddr_i(s1_addr_q[i*FAN_IN +: FAN_IN]),
      .rdata_o(out_data[i*OUT_BITS +: OUT_BITS])
    );
  end

endmodule

// File: tb/tb_lut_layer_pipe.sv
// Directed bench for lut_layer_pipe with a small table model.
module tb_lut_layer_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        cfg_req;
  logic        cfg_ack;
  logic        cfg_we;
  logic [1:0]  cfg_neuron;
  logic [5:0]  cfg_addr;
  logic [0:0]  cfg_data;
  logic [31:0] sample_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  lut_layer_pipe #(
    .N_NEURONS(4),
    .FAN_IN   (6),
    .OUT_BITS (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .cfg_req     (cfg_req),
    .cfg_ack     (cfg_ack),
    .cfg_we      (cfg_we),
    .cfg_neuron  (cfg_neuron),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .sample_count(sample_count)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Programmed table contents per neuron.
  function automatic logic tbl(int n, int a);
    case (n)
      0:       return (a == 14) || (a == 26) || (a == 30);
      1:       return (a % 3) == 0;
      2:       return a[5];
      default: return ^a[5:0];
    endcase
  endfunction

  function automatic logic [3:0] exp_out(logic [23:0] d);
    logic [3:0] r;
    for (int j = 0; j < 4; j++) r[j] = tbl(j, int'(d[j*6 +: 6]));
    return r;
  endfunction

  function automatic logic [23:0] vec(int i);
    logic [23:0] v;
    for (int j = 0; j < 4; j++) v[j*6 +: 6] = 6'((i * 7 + j * 13 + 3) % 64);
    return v;
  endfunction

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_cfg();
    int k = 0;
    cfg_req = 1'b1;
    while (!cfg_ack && k < 20) begin
      tick();
      k++;
    end
    check("cfg_ack_reached", 32'(cfg_ack), 1);
  endtask

  task automatic leave_cfg();
    cfg_req = 1'b0;
    tick();
  endtask

  task automatic load_tables();
    for (int n = 0; n < 4; n++) begin
      for (int a = 0; a < 64; a++) begin
        cfg_we     = 1'b1;
        cfg_neuron = 2'(n);
        cfg_addr   = 6'(a);
        cfg_data   = tbl(n, a);
        tick();
      end
    end
    cfg_we = 1'b0;
  endtask

  // Single sample with out_ready high: checks the two-cycle latency and value.
  task automatic send_one(logic [23:0] d, output logic [3:0] obs);
    out_ready = 1'b1;
    in_data   = d;
    in_valid  = 1'b1;
    check("one_in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("one_valid_lat1", 32'(out_valid), 0);
    tick();
    check("one_valid_lat2", 32'(out_valid), 1);
    check("one_data", 32'(out_data), 32'(exp_out(d)));
    obs = out_data;
    exp_cnt++;
    tick();
    check("one_count", sample_count, exp_cnt);
  endtask

  // Streams n samples; out_ready is held low for the first stall_len cycles.
  task automatic stream(int n, int stall_len, output int acc_in_stall);
    logic [23:0] q[$];
    logic [3:0]  held;
    logic        held_ok;
    int sent, got, cyc, first, last;
    sent = 0; got = 0; cyc = 0; first = -1; last = -1;
    held_ok = 1'b0; held = '0;
    acc_in_stall = 0;
    while (got < n && cyc < n + 40) begin
      out_ready = (cyc >= stall_len);
      in_valid  = (sent < n);
      in_data   = vec(sent);
      @(negedge clk);
      if (in_valid && in_ready) begin
        q.push_back(in_data);
        sent++;
        if (!out_ready) acc_in_stall++;
      end
      if (held_ok) begin
        check("stall_valid_hold", 32'(out_valid), 1);
        check("stall_data_hold", 32'(out_data), 32'(held));
      end
      held_ok = out_valid && !out_ready;
      held    = out_data;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("stream_unexpected", 32'(out_valid), 0);
        end else begin
          check("stream_data", 32'(out_data), 32'(exp_out(q.pop_front())));
        end
        got++;
        exp_cnt++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_got", got, n);
    check("stream_count", sample_count, exp_cnt);
    if (stall_len == 0) begin
      check("stream_first_latency", first, 2);
      check("stream_consecutive", last - first, n - 1);
    end
  endtask

  initial begin
    logic [3:0] obs;
    int acc;
    int k;
    int got;
    logic [23:0] pend[$];

    rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    cfg_req = 1'b0; cfg_we = 1'b0; cfg_neuron = '0; cfg_addr = '0; cfg_data = '0;
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_cfg_ack", 32'(cfg_ack), 0);
    check("rst_count", sample_count, 0);
    rst = 1'b0;

    // Unconfigured: input is never accepted.
    in_valid = 1'b1;
    in_data  = {4{6'd14}};
    for (int i = 0; i < 8; i++) begin
      tick();
      check("uncfg_in_ready", 32'(in_ready), 0);
      check("uncfg_cfg_ack", 32'(cfg_ack), 0);
      check("uncfg_out_valid", 32'(out_valid), 0);
    end
    in_valid = 1'b0;

    enter_cfg();
    load_tables();
    leave_cfg();

    send_one({4{6'd14}}, obs);
    check("n0_addr14_bit0", 32'(obs[0]), 1);
    send_one({4{6'd13}}, obs);
    check("n0_addr13_bit0", 32'(obs[0]), 0);

    // 64 back-to-back samples.
    stream(64, 0, acc);
    check("count_after_64", sample_count, 66);

    // Stall from an empty pipe: exactly two samples fit before back-pressure.
    stream(10, 5, acc);
    check("stall_accepts", acc, 2);

    // Two samples in flight when config is requested; a write in DRAIN is dropped.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = vec(100);
    pend.push_back(in_data);
    tick();
    in_data = {6'd5, 6'd9, 6'd2, 6'd26};
    pend.push_back(in_data);
    tick();
    in_valid = 1'b0;
    cfg_req  = 1'b1;
    k = 0;
    got = 0;
    while (!cfg_ack && k < 20) begin
      if (out_valid) begin
        if (pend.size() == 0) check("drain_unexpected", 32'(out_valid), 0);
        else check("drain_data", 32'(out_data), 32'(exp_out(pend.pop_front())));
        got++;
        exp_cnt++;
      end
      if (k == 1) check("drain_in_ready", 32'(in_ready), 0);
      cfg_we     = (k == 1);
      cfg_neuron = 2'd0;
      cfg_addr   = 6'd14;
      cfg_data   = 1'b0;
      tick();
      k++;
    end
    cfg_we = 1'b0;
    check("drain_delivered", got, 2);
    check("drain_cfg_ack", 32'(cfg_ack), 1);
    check("drain_count", sample_count, exp_cnt);
    leave_cfg();
    send_one({4{6'd14}}, obs);
    check("drain_write_ignored", 32'(obs[0]), 1);

    // Reset mid-stream discards in-flight data but keeps the tables.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = vec(7);
    tick();
    tick();
    tick();
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_count", sample_count, 0);
    check("midrst_in_ready", 32'(in_ready), 0);
    rst     = 1'b0;
    exp_cnt = 0;
    tick();
    check("midrst_no_leftover", 32'(out_valid), 0);
    enter_cfg();
    leave_cfg();
    send_one({4{6'd30}}, obs);
    check("midrst_n0_addr30", 32'(obs[0]), 1);
    stream(8, 0, acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lut_layer_pipe.md
LUT_LAYER_PIPE -- requirements
Module: lut_layer_pipe

Interface
REQ-001 SHALL have parameter N_NEURONS, default 4: number of LUT neurons in the layer.
REQ-002 SHALL have parameter FAN_IN, default 6: address bits per neuron.
REQ-003 SHALL have parameter OUT_BITS, default 1: output bits per neuron.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_data, input, N_NEURONS*FAN_IN: neuron i address in slice [i*FAN_IN +: FAN_IN].
REQ-007 SHALL have port in_valid, input, 1: in_data qualifier.
REQ-008 SHALL have port in_ready, output, 1: sample accepted when in_valid && in_ready.
REQ-009 SHALL have port out_data, output, N_NEURONS*OUT_BITS: neuron i result in slice [i*OUT_BITS +: OUT_BITS].
REQ-010 SHALL have port out_valid, output, 1: out_data qualifier.
REQ-011 SHALL have port out_ready, input, 1: result consumed when out_valid && out_ready.
REQ-012 SHALL have port cfg_req, input, 1: request table-load mode.
REQ-013 SHALL have port cfg_ack, output, 1: table writes permitted.
REQ-014 SHALL have port cfg_we, input, 1: table write strobe.
REQ-015 SHALL have port cfg_neuron, input, clog2(N_NEURONS) (min 1): target neuron.
REQ-016 SHALL have port cfg_addr, input, FAN_IN: table entry.
REQ-017 SHALL have port cfg_data, input, OUT_BITS: entry value.
REQ-018 SHALL have port sample_count, output, 32: results delivered since reset.

Function
REQ-019 SHALL use states UNCFG, RUN, DRAIN, CFG.
REQ-020 SHALL go UNCFG->CFG when cfg_req=1; RUN->DRAIN when cfg_req=1; DRAIN->CFG when both pipeline stages empty; CFG->RUN when cfg_req=0.
REQ-021 SHALL drive in_ready=0 in every state except RUN.
REQ-022 SHALL assert cfg_ack only in CFG; cfg_we outside CFG is ignored.
REQ-023 SHALL, in CFG with cfg_we=1, write table[cfg_neuron][cfg_addr]=cfg_data at that edge; cfg_neuron >= N_NEURONS ignored.
REQ-024 SHALL implement two stages: S1 registers the addresses; S2 registers table lookups onto out_data.
REQ-025 SHALL use enables en2 = !s2_valid || out_ready and en1 = !s1_valid || en2; in_ready = (state==RUN) && en1 (combinational from out_ready).
REQ-026 SHALL, with out_ready held 1, assert out_valid exactly 2 cycles after acceptance and sustain one result per cycle.
REQ-027 SHALL hold out_data and out_valid stable while out_valid && !out_ready; no sample dropped or duplicated.
REQ-028 SHALL preserve acceptance order.
REQ-029 SHALL, in DRAIN, keep delivering in-flight results under normal handshake.
REQ-030 SHALL increment sample_count by 1 on each out_valid && out_ready, wrapping 0xFFFFFFFF->0.
REQ-031 SHALL let a cfg_req deassert during DRAIN be ignored: DRAIN always completes into CFG.

Reset
REQ-032 SHALL, on rst, set state=UNCFG, s1_valid=s2_valid=0, out_valid=0, out_data=0, cfg_ack=0, sample_count=0.
REQ-033 SHALL not reset table contents; tables are undefined until loaded, and rst mid-operation discards in-flight samples.

Structure
REQ-034 SHALL put the state enum and the cfg_neuron width function in package lut_layer_pkg.
REQ-035 SHALL instantiate one sub-module lut_neuron_ram per neuron (2^FAN_IN x OUT_BITS, one write port, one registered read port, distributed-RAM style).

Verification
REQ-036 SHALL check: reset, then in_valid=1 with no config -> in_ready=0, cfg_ack=0, out_valid=0 indefinitely.
REQ-037 SHALL check: cfg_req=1, load neuron0 with 1 only at entries 14, 26, 30 (all else 0), cfg_req=0, send addr 14 -> out_data bit0=1 two cycles later; addr 13 -> 0.
REQ-038 SHALL check: 64 back-to-back samples with out_ready=1 -> 64 results on consecutive cycles, in order, sample_count=64.
REQ-039 SHALL check: out_ready=0 for 5 cycles during streaming -> in_ready falls after 2 accepts; out_data stable; no loss on release.
REQ-040 SHALL check: cfg_req raised with 2 samples in flight -> both delivered, then cfg_ack=1; a write during DRAIN has no effect.
REQ-041 SHALL check: rst asserted mid-stream -> next cycle out_valid=0 and sample_count=0; loaded tables still return their programmed values after reconfiguration handshake.
